// File: rtl/reg_file_bypass_if.sv
// reg_file_bypass_if: decode-side register file port bundle.
// master = decode/hazard logic, slave = register file.
interface reg_file_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              REIn;
  logic [ADDR_W-1:0] A1In;
  logic [ADDR_W-1:0] A2In;
  logic [ADDR_W-1:0] A3In;
  logic [DATA_W-1:0] WD3In;
  logic              WE3;
  logic              PendSetIn;
  logic [ADDR_W-1:0] PendAIn;
  logic [DATA_W-1:0] RD1Out;
  logic [DATA_W-1:0] RD2Out;
  logic              Busy1Out;
  logic              Busy2Out;

  modport master (
    output REIn, A1In, A2In, A3In,
    output WD3In, WE3, PendSetIn, PendAIn,
    input  RD1Out, RD2Out, Busy1Out, Busy2Out
  );

  modport slave (
    input  REIn, A1In, A2In, A3In,
    input  WD3In, WE3, PendSetIn, PendAIn,
    output RD1Out, RD2Out, Busy1Out, Busy2Out
  );
endinterface

// File: rtl/reg_file_bypass.sv
// reg_file_bypass: 2R1W register file with registered reads,
// stall hold, write bypass and load-pending scoreboard.
module reg_file_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             clk,
  input logic             reset,
  reg_file_bypass_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nx;
  logic              wok;
  logic              pok;
  logic [DATA_W-1:0] rd1_nx;
  logic [DATA_W-1:0] rd2_nx;

  // a register 0 write is dropped when it is hard-wired zero
  always_comb begin
    wok = rf.WE3;
    pok = rf.PendSetIn;
    if (ZERO_REG != 0 && rf.A3In == '0) wok = 1'b0;
    if (ZERO_REG != 0 && rf.PendAIn == '0) pok = 1'b0;
  end

  function automatic logic [DATA_W-1:0] rd_val(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = mem[a];
    if (BYPASS != 0 && wok && rf.A3In == a)
      v = rf.WD3In;
    if (ZERO_REG != 0 && a == '0)
      v = '0;
    return v;
  endfunction

  // scoreboard after this edge: write retires, new load wins
  always_comb begin
    pend_nx = pend;
    if (wok) pend_nx[rf.A3In] = 1'b0;
    if (pok) pend_nx[rf.PendAIn] = 1'b1;
  end

  // read data seen by each port this edge
  always_comb begin
    rd1_nx = rd_val(rf.A1In);
    rd2_nx = rd_val(rf.A2In);
  end

  // register array and pending vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (wok) mem[rf.A3In] <= rf.WD3In;
      pend <= pend_nx;
    end
  end

  // registered read ports, held while REIn is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf.RD1Out   <= '0;
      rf.RD2Out   <= '0;
      rf.Busy1Out <= 1'b0;
      rf.Busy2Out <= 1'b0;
    end else if (rf.REIn) begin
      rf.RD1Out   <= rd1_nx;
      rf.RD2Out   <= rd2_nx;
      rf.Busy1Out <= pend_nx[rf.A1In];
      rf.Busy2Out <= pend_nx[rf.A2In];
    end
  end
endmodule

// File: tb/tb_reg_file_bypass.sv
// tb_reg_file_bypass: scoreboard bench, runs a BYPASS=1 and
// a BYPASS=0 instance on identical stimulus.
module tb_reg_file_bypass;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_file_bypass_if bus ();
  reg_file_bypass_if bus0 ();

  assign bus0.REIn      = bus.REIn;
  assign bus0.A1In      = bus.A1In;
  assign bus0.A2In      = bus.A2In;
  assign bus0.A3In      = bus.A3In;
  assign bus0.WD3In     = bus.WD3In;
  assign bus0.WE3       = bus.WE3;
  assign bus0.PendSetIn = bus.PendSetIn;
  assign bus0.PendAIn   = bus.PendAIn;

  reg_file_bypass #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rf(bus.slave)
  );
  reg_file_bypass #(.BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .rf(bus0.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] r1, r2, n1, n2;
    logic        b1, b2;
  } exp_t;

  exp_t        q[$];
  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] mem [32];
  logic [31:0] pend;
  logic [31:0] o_r1, o_r2, o_n1, o_n2;
  logic        o_b1, o_b2;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdm(
    logic [4:0] a, bit byp, bit wok,
    logic [4:0] a3, logic [31:0] wd
  );
    if (a == 5'd0) return 32'h0;
    if (byp && wok && a3 == a) return wd;
    return mem[a];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    pend = '0;
    o_r1 = 0; o_r2 = 0; o_n1 = 0; o_n2 = 0;
    o_b1 = 0; o_b2 = 0;
  endtask

  task automatic step(
    string tag, bit re, logic [4:0] a1, logic [4:0] a2,
    bit we, logic [4:0] a3, logic [31:0] wd,
    bit ps, logic [4:0] pa
  );
    exp_t        e;
    exp_t        g;
    bit          wok;
    logic [31:0] pn;
    bus.REIn = re; bus.A1In = a1; bus.A2In = a2;
    bus.WE3 = we; bus.A3In = a3; bus.WD3In = wd;
    bus.PendSetIn = ps; bus.PendAIn = pa;
    wok = we && a3 != 5'd0;
    pn = pend;
    if (wok) pn[a3] = 1'b0;
    if (ps && pa != 5'd0) pn[pa] = 1'b1;
    if (re) begin
      o_r1 = rdm(a1, 1, wok, a3, wd);
      o_r2 = rdm(a2, 1, wok, a3, wd);
      o_n1 = rdm(a1, 0, wok, a3, wd);
      o_n2 = rdm(a2, 0, wok, a3, wd);
      o_b1 = pn[a1];
      o_b2 = pn[a2];
    end
    if (wok) mem[a3] = wd;
    pend = pn;
    e.tag = tag;
    e.r1 = o_r1; e.r2 = o_r2; e.n1 = o_n1; e.n2 = o_n2;
    e.b1 = o_b1; e.b2 = o_b2;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk({g.tag, ".rd1"}, bus.RD1Out, g.r1);
    chk({g.tag, ".rd2"}, bus.RD2Out, g.r2);
    chk({g.tag, ".b1"}, {31'b0, bus.Busy1Out}, {31'b0, g.b1});
    chk({g.tag, ".b2"}, {31'b0, bus.Busy2Out}, {31'b0, g.b2});
    chk({g.tag, ".nb_rd1"}, bus0.RD1Out, g.n1);
    chk({g.tag, ".nb_rd2"}, bus0.RD2Out, g.n2);
    chk({g.tag, ".nb_b1"}, {31'b0, bus0.Busy1Out}, {31'b0, g.b1});
    chk({g.tag, ".nb_b2"}, {31'b0, bus0.Busy2Out}, {31'b0, g.b2});
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".rd1"}, bus.RD1Out, 32'h0);
    chk({tag, ".rd2"}, bus.RD2Out, 32'h0);
    chk({tag, ".b1"}, {31'b0, bus.Busy1Out}, 32'h0);
    chk({tag, ".b2"}, {31'b0, bus.Busy2Out}, 32'h0);
    chk({tag, ".nb_rd1"}, bus0.RD1Out, 32'h0);
    chk({tag, ".nb_b1"}, {31'b0, bus0.Busy1Out}, 32'h0);
  endtask

  initial begin
    bus.REIn = 0; bus.A1In = 0; bus.A2In = 0;
    bus.WE3 = 0; bus.A3In = 0; bus.WD3In = 0;
    bus.PendSetIn = 0; bus.PendAIn = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 reset = 1'b0;

    for (int i = 0; i < 32; i++)
      step("rd_all", 1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);

    step("wr_r5", 1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step("rd_r5", 1, 5, 5, 0, 0, 0, 0, 0);
    step("wr_r0", 1, 0, 0, 1, 0, 32'h1234, 0, 0);
    step("rd_r0", 1, 0, 5, 0, 0, 0, 0, 0);

    step("wr_r7", 1, 0, 0, 1, 7, 32'h77, 0, 0);
    step("byp_r7", 1, 7, 7, 1, 7, 32'hA5A5A5A5, 0, 0);
    step("rd_r7", 1, 7, 7, 0, 0, 0, 0, 0);

    step("ld_r3", 1, 0, 0, 1, 3, 32'h11, 0, 0);
    step("ld_r4", 1, 0, 0, 1, 4, 32'h22, 0, 0);
    step("rd_34", 1, 3, 4, 0, 0, 0, 0, 0);
    step("stall", 0, 8, 9, 1, 3, 32'h99, 0, 0);
    step("stall2", 0, 1, 2, 0, 0, 0, 1, 4);
    step("unstall", 1, 3, 4, 0, 0, 0, 0, 0);
    step("clr_r4", 1, 3, 4, 1, 4, 32'h22, 0, 0);

    step("pend_r9", 1, 9, 0, 0, 0, 0, 1, 9);
    step("rd_r9", 1, 9, 9, 0, 0, 0, 0, 0);
    step("ret_r9", 1, 9, 9, 1, 9, 32'h55, 0, 0);
    step("pend_r0", 1, 0, 9, 0, 0, 0, 1, 0);
    step("coll_r9a", 1, 9, 0, 0, 0, 0, 1, 9);
    step("coll_r9", 1, 9, 9, 1, 9, 32'h66, 1, 9);
    step("still_r9", 1, 9, 9, 0, 0, 0, 0, 0);
    step("clr_r9", 1, 9, 9, 1, 9, 32'h77, 0, 0);

    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
           $urandom, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 31)));

    step("pre_rst", 1, 5, 3, 1, 12, 32'hCAFE, 1, 12);
    step("pre_rst2", 1, 12, 5, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    mreset();
    #2 reset = 1'b0;
    step("post_rst", 1, 5, 12, 0, 0, 0, 0, 0);
    step("post_wr", 1, 5, 5, 1, 5, 32'h5A, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/reg_file_bypass.md
# reg_file_bypass

Parametrised successor to the MIPS datapath register file. It provides two registered read ports with read-enable hold for stalls, one write port, and write-to-read bypass. Register 0 can be configured as hard-wired zero. A per-register pending scoreboard flags operands still awaited from in-flight loads. It sits in the decode stage, between instruction decode and the ID/EX pipeline register, and feeds the hazard unit.

## Interface
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, 1: same-cycle write data is forwarded to read outputs; 0: old contents are read

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- REIn  in  1  read enable; 0 holds RD1Out/RD2Out/Busy1Out/Busy2Out (stall)
- A1In  in  ADDR_W  read address port 1 (rs)
- A2In  in  ADDR_W  read address port 2 (rt)
- A3In  in  ADDR_W  write address (rd)
- WD3In  in  DATA_W  write data
- WE3  in  1  write enable
- PendSetIn  in  1  mark PendAIn as pending (load issued)
- PendAIn  in  ADDR_W  register to mark pending
- RD1Out  out  DATA_W  registered read data, port 1
- RD2Out  out  DATA_W  registered read data, port 2
- Busy1Out  out  1  registered pending flag for A1In
- Busy2Out  out  1  registered pending flag for A2In

## Operation
- Reset is asynchronous. While reset is high, all 2**ADDR_W registers, the pending vector and all four outputs are held at 0.
- Write: on each edge with WE3=1, registry[A3In] <= WD3In. If ZERO_REG=1 and A3In=0, the write is dropped.
- Read on each edge with REIn=1:
  - RDxOut <= value of register Ax.
  - If BYPASS=1, WE3=1, A3In=Ax and the write is not dropped, WD3In is returned instead.
  - If ZERO_REG=1 and Ax=0, the output is always 0.
- REIn=0: all four outputs hold their previous value. Writes and scoreboard updates still occur.
- Scoreboard, with one pending bit per register:
  - The bit is set when PendSetIn=1, at PendAIn.
  - The bit is cleared by a non-dropped write to that address.
  - If a set and a clear hit the same address in the same cycle, the set wins (a new load replaces the old one).
  - PendAIn=0 with ZERO_REG=1 has no effect.
- Busy outputs: with REIn=1, Busyx <= pending_next[Ax], where pending_next is the vector after this edge's set/clear. A write that retires a load in the same cycle as the read therefore reports not-busy.
- Both ports may address the same register, and both return identical data and busy flags.

## Timing
- Read latency: 1 cycle. Address and enable are sampled on edge N, and data is valid after edge N.
- Write-to-read: with BYPASS=1, the same edge returns the new data. With BYPASS=0, the new data is visible on the next read edge.
- Pending set to busy: visible on the same edge as the set.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- After reset deasserts, the first edge performs a normal read and write.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then read all addresses with REIn=1 -> every RDxOut=0 and Busy=0. Assert reset mid-burst -> outputs go to 0 before the next edge.
- Write 0xDEADBEEF to r5, then read r5 on the next cycle -> RD1Out=0xDEADBEEF. Write 0x1234 to r0 and read r0 -> RD1Out=0 with ZERO_REG=1.
- Same edge: WE3=1, A3In=7, WD3In=0xA5A5A5A5, A1In=A2In=7 -> both outputs are 0xA5A5A5A5 with BYPASS=1. With BYPASS=0 they show the old value, and the new value appears on the following edge.
- Stall: load r3=0x11 and r4=0x22, read A1=3/A2=4, then REIn=0 while changing the addresses and writing r3=0x99 -> outputs hold 0x11/0x22. Raising REIn gives 0x99/0x22.
- Scoreboard: PendSetIn with r9, then read r9 -> Busy1Out=1. Write r9=0x55 while reading r9 -> RD1Out=0x55 and Busy1Out=0.
- Scoreboard collision: same-cycle PendSetIn and write on r9 -> Busy stays 1. A later write to r9 clears it.
